dspi_ctrl_node: RTL and testbench

- Parametrised DSPI pipeline node with one registered stage on the forward (Front->Back) data path and one on the backward instruction path.
- Terminates relative-addressed control packets whose ChannelID selector is 0: a 32-bit register file, per-stream data-packet counters, a sticky EOS bitmap and a user status word.
- Generates CP_A_CTRL_READ_RESPONSE_32b packets for read requests.
- Every other packet passes through with a fixed 1-cycle latency; non-recipient relative packets have their selector decremented.

---
 rtl/dspi_pkg.sv | 32 +++
 rtl/dspi_ctrl_regfile.sv | 87 ++++++++
 rtl/dspi_ctrl_node.sv | 174 +++++++++++++++++
 tb/tb_dspi_ctrl_node.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dspi_pkg.sv
// Shared DSPI encodings: instruction types, control-packet chunk codes,
// packet-type bit positions and the control-node address map.
package dspi_pkg;

  typedef enum logic [2:0] {
    INSTR_IDLE      = 3'd0,
    INSTR_REQUEST   = 3'd2,
    INSTR_LOOKAHEAD = 3'd3,
    INSTR_REWIND    = 3'd5,
    INSTR_RESTART   = 3'd6,
    INSTR_FINISH    = 3'd7
  } instr_e;

  // Absolute control chunk codes (ChunkID MSB = 0)
  localparam int CP_A_EOS                    = 0;
  localparam int CP_A_CTRL_READ_RESPONSE_32b = 1;
  localparam int CP_A_MEM_READ_REQUEST_512b  = 2;
  localparam int CP_A_MEM_READ_RESPONSE_512b = 3;
  localparam int CP_A_MEM_WRITE_512b         = 4;

  // Relative control chunk codes (ChunkID MSB = 1)
  localparam int CP_R_CTRL_READ_REQUEST_32b = 0;
  localparam int CP_R_CTRL_WRITE_32b        = 1;

  localparam int TYPE_DATA_BIT = 0;
  localparam int TYPE_CTRL_BIT = 1;

  localparam logic [11:0] ADDR_CNT_BASE    = 12'h100;
  localparam logic [11:0] ADDR_EOS         = 12'h200;
  localparam logic [11:0] ADDR_STATUS      = 12'h300;

endpackage

// File: rtl/dspi_ctrl_regfile.sv
// Control-node register space: config registers, per-stream packet counters,
// sticky EOS bitmap and status word behind a single-cycle access port.
module dspi_ctrl_regfile
  import dspi_pkg::*;
#(
  parameter int STREAM_ID_NUM   = 16,
  parameter int REG_NUM         = 8,
  parameter int STREAM_ID_WIDTH = $clog2(STREAM_ID_NUM)
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en_i,
  input  logic [11:0]                addr_i,
  input  logic [31:0]                wdata_i,
  output logic [31:0]                rdata_o,
  input  logic                       inc_en_i,
  input  logic [STREAM_ID_WIDTH-1:0] inc_sid_i,
  input  logic                       eos_set_i,
  input  logic [STREAM_ID_WIDTH-1:0] eos_sid_i,
  input  logic [31:0]                status_i,
  output logic [32*REG_NUM-1:0]      cfg_o
);

  logic [31:0]              cfg_q [REG_NUM];
  logic [31:0]              cnt_q [STREAM_ID_NUM];
  logic [STREAM_ID_NUM-1:0] eos_q;
  logic [STREAM_ID_NUM-1:0] eos_d;

  genvar gi;
  generate
    for (gi = 0; gi < REG_NUM; gi++) begin : g_cfg
      always_ff @(posedge clk) begin
        if (srst) begin
          cfg_q[gi] <= '0;
        end else if (wr_en_i && addr_i == 12'(gi)) begin
          cfg_q[gi] <= wdata_i;
        end
      end
      assign cfg_o[32*gi +: 32] = cfg_q[gi];
    end

    for (gi = 0; gi < STREAM_ID_NUM; gi++) begin : g_cnt
      // Write-clear and increment never coincide: one packet per cycle.
      always_ff @(posedge clk) begin
        if (srst) begin
          cnt_q[gi] <= '0;
        end else if (wr_en_i && addr_i == ADDR_CNT_BASE + 12'(gi)) begin
          cnt_q[gi] <= '0;
        end else if (inc_en_i && inc_sid_i == STREAM_ID_WIDTH'(gi) &&
                     cnt_q[gi] != 32'hFFFF_FFFF) begin
          cnt_q[gi] <= cnt_q[gi] + 32'd1;
        end
      end
    end
  endgenerate

  always_comb begin
    eos_d = eos_q;
    if (eos_set_i) begin
      eos_d[eos_sid_i] = 1'b1;
    end else if (wr_en_i && addr_i == ADDR_EOS) begin
      eos_d = eos_q & ~wdata_i[STREAM_ID_NUM-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      eos_q <= '0;
    end else begin
      eos_q <= eos_d;
    end
  end

  // Read returns pre-update state; the caller registers it.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (addr_i == 12'(i)) rdata_o = cfg_q[i];
    end
    for (int i = 0; i < STREAM_ID_NUM; i++) begin
      if (addr_i == ADDR_CNT_BASE + 12'(i)) rdata_o = cnt_q[i];
    end
    if (addr_i == ADDR_EOS)    rdata_o = 32'(eos_q);
    if (addr_i == ADDR_STATUS) rdata_o = status_i;
  end

endmodule

// File: rtl/dspi_ctrl_node.sv
// DSPI pipeline node: one forward and one backward register stage, terminating
// relative control packets addressed to this node (ChannelID selector 0).
module dspi_ctrl_node
  import dspi_pkg::*;
#(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 3,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter int REG_NUM                     = 8,
  parameter int STREAM_ID_WIDTH             = $clog2(STREAM_ID_NUM),
  parameter int CHUNK_ID_WIDTH              = $clog2(CHUNK_ID_NUM),
  parameter int CHANNEL_ID_WIDTH            = $clog2(CHANNEL_ID_NUM),
  parameter int NUM_32B_FIELDS              = DATA_WIDTH / 32
) (
  input  logic                                   clk,
  input  logic                                   rstIn,
  output logic                                   rstOut,

  input  logic [DATA_WIDTH-1:0]                  Front_Data,
  input  logic [1:0]                             Front_Type,
  input  logic                                   Front_Last,
  input  logic [STREAM_ID_WIDTH-1:0]             Front_StreamID,
  input  logic [CHUNK_ID_WIDTH-1:0]              Front_ChunkID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            Front_ChannelID,
  input  logic [STATE_WIDTH-1:0]                 Front_State,

  output logic [DATA_WIDTH-1:0]                  Back_Data,
  output logic [1:0]                             Back_Type,
  output logic                                   Back_Last,
  output logic [STREAM_ID_WIDTH-1:0]             Back_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]              Back_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0]            Back_ChannelID,
  output logic [STATE_WIDTH-1:0]                 Back_State,

  input  logic [INSTRUCTION_WIDTH-1:0]           Back_InstructionType,
  input  logic [STREAM_ID_WIDTH-1:0]             Back_InstructionStreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            Back_InstructionChannelID,
  input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Back_InstructionParameter,

  output logic [INSTRUCTION_WIDTH-1:0]           Front_InstructionType,
  output logic [STREAM_ID_WIDTH-1:0]             Front_InstructionStreamID,
  output logic [CHANNEL_ID_WIDTH-1:0]            Front_InstructionChannelID,
  output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Front_InstructionParameter,

  output logic [32*REG_NUM-1:0]                  cfgOut,
  input  logic [31:0]                            statusIn
);

  localparam int CLW = CHUNK_ID_WIDTH - 1;

  logic rst_q;

  logic [DATA_WIDTH-1:0]       data_q,  data_d;
  logic [1:0]                  type_q,  type_d;
  logic                        last_q,  last_d;
  logic [STREAM_ID_WIDTH-1:0]  sid_q,   sid_d;
  logic [CHUNK_ID_WIDTH-1:0]   cid_q,   cid_d;
  logic [CHANNEL_ID_WIDTH-1:0] chid_q,  chid_d;
  logic [STATE_WIDTH-1:0]      state_q, state_d;

  logic [INSTRUCTION_WIDTH-1:0]           itype_q;
  logic [STREAM_ID_WIDTH-1:0]             isid_q;
  logic [CHANNEL_ID_WIDTH-1:0]            ichid_q;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] iparam_q;

  logic           is_ctrl, is_data, is_rel, consume, is_wr, is_rd, eos_set;
  logic [CLW-1:0] chunk_code;
  logic [31:0]    rdata;

  always_ff @(posedge clk) begin
    rst_q <= rstIn;
  end
  assign rstOut = rst_q;

  // 2'b11 decodes as control; the data bit only counts when control is clear.
  assign is_ctrl    = Front_Type[TYPE_CTRL_BIT];
  assign is_data    = Front_Type[TYPE_DATA_BIT] & ~Front_Type[TYPE_CTRL_BIT];
  assign is_rel     = Front_ChunkID[CHUNK_ID_WIDTH-1];
  assign chunk_code = Front_ChunkID[CLW-1:0];
  assign consume    = is_ctrl & is_rel & (Front_ChannelID == '0);
  assign is_wr      = consume & (chunk_code == CLW'(CP_R_CTRL_WRITE_32b));
  assign is_rd      = consume & (chunk_code == CLW'(CP_R_CTRL_READ_REQUEST_32b));
  assign eos_set    = is_ctrl & ~is_rel & (chunk_code == CLW'(CP_A_EOS));

  dspi_ctrl_regfile #(
    .STREAM_ID_NUM   (STREAM_ID_NUM),
    .REG_NUM         (REG_NUM),
    .STREAM_ID_WIDTH (STREAM_ID_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .srst      (rst_q),
    .wr_en_i   (is_wr),
    .addr_i    (Front_State[11:0]),
    .wdata_i   (Front_Data[31:0]),
    .rdata_o   (rdata),
    .inc_en_i  (is_data),
    .inc_sid_i (Front_StreamID),
    .eos_set_i (eos_set),
    .eos_sid_i (Front_StreamID),
    .status_i  (statusIn),
    .cfg_o     (cfgOut)
  );

  always_comb begin
    data_d  = Front_Data;
    type_d  = Front_Type;
    last_d  = Front_Last;
    sid_d   = Front_StreamID;
    cid_d   = Front_ChunkID;
    chid_d  = Front_ChannelID;
    state_d = Front_State;
    if (consume) begin
      data_d = '0;
      type_d = 2'b00;
      last_d = 1'b0;
      cid_d  = '0;
      chid_d = '0;
      if (is_rd) begin
        data_d = {NUM_32B_FIELDS{rdata}};
        type_d = 2'b10;
        last_d = 1'b1;
        cid_d  = {1'b0, CLW'(CP_A_CTRL_READ_RESPONSE_32b)};
      end
    end else if (is_ctrl && is_rel) begin
      chid_d = Front_ChannelID - CHANNEL_ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_q) begin
      data_q   <= '0;
      type_q   <= '0;
      last_q   <= 1'b0;
      sid_q    <= '0;
      cid_q    <= '0;
      chid_q   <= '0;
      state_q  <= '0;
      itype_q  <= INSTRUCTION_WIDTH'(INSTR_IDLE);
      isid_q   <= '0;
      ichid_q  <= '0;
      iparam_q <= '0;
    end else begin
      data_q   <= data_d;
      type_q   <= type_d;
      last_q   <= last_d;
      sid_q    <= sid_d;
      cid_q    <= cid_d;
      chid_q   <= chid_d;
      state_q  <= state_d;
      itype_q  <= Back_InstructionType;
      isid_q   <= Back_InstructionStreamID;
      ichid_q  <= Back_InstructionChannelID;
      iparam_q <= Back_InstructionParameter;
    end
  end

  assign Back_Data      = data_q;
  assign Back_Type      = type_q;
  assign Back_Last      = last_q;
  assign Back_StreamID  = sid_q;
  assign Back_ChunkID   = cid_q;
  assign Back_ChannelID = chid_q;
  assign Back_State     = state_q;

  assign Front_InstructionType      = itype_q;
  assign Front_InstructionStreamID  = isid_q;
  assign Front_InstructionChannelID = ichid_q;
  assign Front_InstructionParameter = iparam_q;

endmodule

// File: tb/tb_dspi_ctrl_node.sv
// Directed bench for dspi_ctrl_node with hand-computed expected values.
module tb_dspi_ctrl_node;

  logic         clk = 1'b0;
  logic         rstIn;
  logic         rstOut;
  logic [511:0] Front_Data;
  logic [1:0]   Front_Type;
  logic         Front_Last;
  logic [3:0]   Front_StreamID;
  logic [4:0]   Front_ChunkID;
  logic [9:0]   Front_ChannelID;
  logic [31:0]  Front_State;
  logic [511:0] Back_Data;
  logic [1:0]   Back_Type;
  logic         Back_Last;
  logic [3:0]   Back_StreamID;
  logic [4:0]   Back_ChunkID;
  logic [9:0]   Back_ChannelID;
  logic [31:0]  Back_State;
  logic [2:0]   Back_InstructionType;
  logic [3:0]   Back_InstructionStreamID;
  logic [9:0]   Back_InstructionChannelID;
  logic [15:0]  Back_InstructionParameter;
  logic [2:0]   Front_InstructionType;
  logic [3:0]   Front_InstructionStreamID;
  logic [9:0]   Front_InstructionChannelID;
  logic [15:0]  Front_InstructionParameter;
  logic [255:0] cfgOut;
  logic [31:0]  statusIn;

  int n_cmp = 0;
  int n_bad = 0;

  dspi_ctrl_node dut (
    .clk                        (clk),
    .rstIn                      (rstIn),
    .rstOut                     (rstOut),
    .Front_Data                 (Front_Data),
    .Front_Type                 (Front_Type),
    .Front_Last                 (Front_Last),
    .Front_StreamID             (Front_StreamID),
    .Front_ChunkID              (Front_ChunkID),
    .Front_ChannelID            (Front_ChannelID),
    .Front_State                (Front_State),
    .Back_Data                  (Back_Data),
    .Back_Type                  (Back_Type),
    .Back_Last                  (Back_Last),
    .Back_StreamID              (Back_StreamID),
    .Back_ChunkID               (Back_ChunkID),
    .Back_ChannelID             (Back_ChannelID),
    .Back_State                 (Back_State),
    .Back_InstructionType       (Back_InstructionType),
    .Back_InstructionStreamID   (Back_InstructionStreamID),
    .Back_InstructionChannelID  (Back_InstructionChannelID),
    .Back_InstructionParameter  (Back_InstructionParameter),
    .Front_InstructionType      (Front_InstructionType),
    .Front_InstructionStreamID  (Front_InstructionStreamID),
    .Front_InstructionChannelID (Front_InstructionChannelID),
    .Front_InstructionParameter (Front_InstructionParameter),
    .cfgOut                     (cfgOut),
    .statusIn                   (statusIn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic l, input logic [3:0] s,
                      input logic [4:0] c, input logic [9:0] ch,
                      input logic [31:0] st, input logic [511:0] d);
    Front_Type      = t;
    Front_Last      = l;
    Front_StreamID  = s;
    Front_ChunkID   = c;
    Front_ChannelID = ch;
    Front_State     = st;
    Front_Data      = d;
    step();
    Front_Type      = 2'b00;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [3:0] sid,
                    input logic [31:0] exp);
    send(2'b10, 1'b0, sid, 5'h10, 10'd0, addr, {16{32'h1357_9BDF}});
    check({tag, "_type"}, 512'(Back_Type), 512'(2'b10));
    check({tag, "_data"}, Back_Data, {16{exp}});
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] val);
    send(2'b10, 1'b0, 4'd0, 5'h11, 10'd0, addr, {{15{32'hFFFF_0000}}, val});
    check({tag, "_slot_empty"}, 512'(Back_Type), 512'(2'b00));
  endtask

  logic [511:0] pat;

  initial begin
    rstIn = 1'b1;
    Front_Data = '0; Front_Type = 2'b00; Front_Last = 1'b0;
    Front_StreamID = '0; Front_ChunkID = '0; Front_ChannelID = '0; Front_State = '0;
    Back_InstructionType = 3'd0; Back_InstructionStreamID = '0;
    Back_InstructionChannelID = '0; Back_InstructionParameter = '0;
    statusIn = 32'hCAFE_F00D;
    pat = '0;
    for (int i = 0; i < 16; i++) pat[32*i +: 32] = 32'h0101_0101 * (i + 1);
    repeat (3) step();
    rstIn = 1'b0;
    step();
    step();

    check("rst_rstOut", 512'(rstOut), 512'(1'b0));
    check("rst_back_type", 512'(Back_Type), 512'(2'b00));
    check("rst_instr_type", 512'(Front_InstructionType), 512'(3'd0));
    check("rst_cfg", 512'(cfgOut), 512'(0));

    // Data passthrough
    send(2'b01, 1'b1, 4'd3, 5'h02, 10'd5, 32'h55, pat);
    check("pass_type", 512'(Back_Type), 512'(2'b01));
    check("pass_data", Back_Data, pat);
    check("pass_sid", 512'(Back_StreamID), 512'(4'd3));
    check("pass_chid", 512'(Back_ChannelID), 512'(10'd5));
    check("pass_cid", 512'(Back_ChunkID), 512'(5'h02));
    check("pass_state", 512'(Back_State), 512'(32'h55));
    check("pass_last", 512'(Back_Last), 512'(1'b1));
    rd("cnt3", 32'h103, 4'd9, 32'd1);
    check("cnt3_cid", 512'(Back_ChunkID), 512'(5'h01));
    check("cnt3_chid", 512'(Back_ChannelID), 512'(10'd0));
    check("cnt3_last", 512'(Back_Last), 512'(1'b1));
    check("cnt3_sid", 512'(Back_StreamID), 512'(4'd9));
    check("cnt3_state", 512'(Back_State), 512'(32'h103));

    // Relative packet for a later node: selector decrements
    send(2'b10, 1'b0, 4'd2, 5'h11, 10'd4, 32'h2, {16{32'hDEAD_BEEF}});
    check("dec_chid", 512'(Back_ChannelID), 512'(10'd3));
    check("dec_cid", 512'(Back_ChunkID), 512'(5'h11));
    check("dec_type", 512'(Back_Type), 512'(2'b10));
    check("dec_cfg", 512'(cfgOut), 512'(0));

    // Write then read
    wr("wr2", 32'h2, 32'hA5A5_5A5A);
    check("wr2_cfg", 512'(cfgOut[95:64]), 512'(32'hA5A5_5A5A));
    rd("rd2", 32'h2, 4'd7, 32'hA5A5_5A5A);
    check("rd2_sid", 512'(Back_StreamID), 512'(4'd7));
    check("rd2_state", 512'(Back_State), 512'(32'h2));
    check("rd2_cid", 512'(Back_ChunkID), 512'(5'h01));
    rd("rd2_hiaddr", 32'h0000_1002, 4'd1, 32'hA5A5_5A5A);

    // EOS bitmap and write-1-to-clear
    send(2'b10, 1'b1, 4'd1, 5'h00, 10'd0, 32'h0, '0);
    check("eos1_fwd_type", 512'(Back_Type), 512'(2'b10));
    check("eos1_fwd_chid", 512'(Back_ChannelID), 512'(10'd0));
    send(2'b10, 1'b1, 4'd4, 5'h00, 10'd0, 32'h0, '0);
    rd("eos_a", 32'h200, 4'd0, 32'h12);
    wr("eos_w1c", 32'h200, 32'h2);
    rd("eos_b", 32'h200, 4'd0, 32'h10);

    // Status, unmapped read, and counter clear on write
    rd("status", 32'h300, 4'd0, 32'hCAFE_F00D);
    rd("unmapped", 32'h0FF, 4'd0, 32'h0);
    wr("cnt3_clr", 32'h103, 32'h1234);
    rd("cnt3_cleared", 32'h103, 4'd0, 32'd0);

    // Instruction path
    Back_InstructionType      = 3'd2;
    Back_InstructionStreamID  = 4'd9;
    Back_InstructionChannelID = 10'h33;
    Back_InstructionParameter = 16'h1234;
    step();
    check("ins_type", 512'(Front_InstructionType), 512'(3'd2));
    check("ins_sid", 512'(Front_InstructionStreamID), 512'(4'd9));
    check("ins_chid", 512'(Front_InstructionChannelID), 512'(10'h33));
    check("ins_param", 512'(Front_InstructionParameter), 512'(16'h1234));

    // Reset mid-stream during back-to-back data packets
    Back_InstructionType = 3'd5;
    send(2'b01, 1'b0, 4'd3, 5'h02, 10'd1, 32'h0, pat);
    Front_Type = 2'b01;
    rstIn = 1'b1;
    step();
    check("mid_rstOut_hi", 512'(rstOut), 512'(1'b1));
    check("mid_last_pkt", 512'(Back_Type), 512'(2'b01));
    rstIn = 1'b0;
    step();
    check("mid_back_type", 512'(Back_Type), 512'(2'b00));
    check("mid_cfg", 512'(cfgOut), 512'(0));
    check("mid_instr", 512'(Front_InstructionType), 512'(3'd0));
    check("mid_rstOut_lo", 512'(rstOut), 512'(1'b0));
    Front_Type = 2'b00;
    rd("mid_cnt3", 32'h103, 4'd0, 32'd0);
    check("resume_instr", 512'(Front_InstructionType), 512'(3'd5));
    send(2'b01, 1'b0, 4'd3, 5'h02, 10'd1, 32'h0, pat);
    check("resume_data", Back_Data, pat);
    rd("resume_cnt3", 32'h103, 4'd0, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
